gps_pps_divider: RTL and testbench
==================================

# gps_pps_divider

Parametrised phase counter and second-tick generator disciplined by the GPS 1PPS input. Free-runs modulo DIV to produce a one-cycle `tick` per second and a phase value `q`. Measures the interval between PPS edges and realigns `q` to each accepted edge. A lock/holdover state machine qualifies the GPS pulse. Sits between the GPS receiver's PPS pin and the time-of-day / display logic.

## Interface
- WIDTH, 28: width of `q`, `last_period` and the internal period counter; DIV+TOL < 2^WIDTH required.
- DIV, 50_000_000: nominal clk cycles per second.
- TOL, 1000: accepted |period − DIV| in cycles.
- LOCK_CNT, 3: consecutive good periods needed to lock.
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset.
- pps  in  1  raw GPS 1PPS, asynchronous to clk.
- en  in  1  phase-counter enable; gates `q` only.
- q  out  WIDTH  phase within current second, 0..DIV−1.
- tick  out  1  one-cycle pulse in the cycle `q` becomes 0.
- locked  out  1  high in LOCKED.
- holdover  out  1  high in HOLDOVER.
- last_period  out  WIDTH  cycles between the last two PPS rises.
- period_valid  out  1  one-cycle pulse when `last_period` updates.

## Operation
- PPS front end: 2-flop synchroniser plus edge flop. `rise` = sync_out & ~edge_q, one cycle per rising edge.
- Period counter `pcnt`: runs every cycle regardless of `en` and saturates at all-ones.
  - On `rise`: `last_period` <= pcnt+1, `period_valid`=1, pcnt <= 0.
  - Rises P cycles apart give last_period = P.
- Good pulse: DIV−TOL ≤ pcnt+1 ≤ DIV+TOL. Any other rise is a bad pulse.
- Timeout: pcnt+1 == DIV+TOL with no `rise` in that cycle.
- Phase counter, when en=1: q increments. On q==DIV−1, q wraps to 0 and `tick` pulses.
- Realign: q <= 0 and tick=1 regardless of `en`, except tick is suppressed if q < TOL (this second has already ticked).
- FSM states and transitions:
  - UNLOCKED: any rise → ACQUIRE; realign; good count = 0.
  - ACQUIRE:
    - Any rise realigns.
    - Good rise: good count +1; reaching LOCK_CNT → LOCKED.
    - Bad rise: good count = 0.
    - Timeout → UNLOCKED.
  - LOCKED:
    - Good rise realigns.
    - Bad rise → ACQUIRE, good count = 0, no realign.
    - Timeout → HOLDOVER.
  - HOLDOVER: q free-runs. Any rise → ACQUIRE, realign, good count = 0.
- Simultaneous events:
  - Rise and natural wrap in the same cycle: one tick, q=0.
  - Rise and timeout in the same cycle: the rise wins.

## Timing
- Reset values: q=0, tick=0, locked=0, holdover=0, last_period=0, period_valid=0, pcnt=0, state UNLOCKED, sync/edge flops 0.
  - A pps already high during reset produces one `rise` 3 cycles after release.
- PPS edge to `rise`: 2–3 cycles. `q`=0, `tick`, `period_valid` and state outputs are registered, 1 cycle after `rise`.
- Natural wrap: tick is high in the cycle q reads 0, DIV enabled cycles after the previous tick.
- Reset asserted mid-operation: all outputs return to reset values at the next clk edge, whatever the state.

## Structure
- Shared package/header `gps_clk_pkg`:
  - FSM state encodings (UNLOCKED=0, ACQUIRE=1, LOCKED=2, HOLDOVER=3).
  - Default DIV/TOL/WIDTH constants, shared with the time-of-day logic.
- Sub-module `pps_sync`: synchroniser + rising-edge detector. Ports clk, reset, pps, rise.
- Top holds `pcnt`, `q`, the window compare and the FSM.

## Test plan
Parameters for all scenarios: WIDTH=8, DIV=100, TOL=5, LOCK_CNT=3.
- Free-running: release reset, en=1, no pps → q counts 0..99, tick every 100 cycles, locked=0, holdover=0, period_valid never pulses.
- Acquire and lock: pps rises every 100 cycles, 4 rises → last_period=100 with period_valid on rises 2–4; locked=1 one cycle after rise 4's `rise`; q=0 after each rise.
- Window edges, in LOCKED:
  - Rise at period 105 → realign, stays locked.
  - Next rise at period 94 → ACQUIRE, locked=0, last_period=94, q not reset.
- Holdover: stop pps in LOCKED → holdover=1 at pcnt+1=105, locked=0, tick continues every 100. A later rise → ACQUIRE, holdover=0, q=0.
- Reset mid-run: reset=0 for one cycle in LOCKED with q=57 → next edge q=0, locked=0, last_period=0, state UNLOCKED.
- Enable: en=0 for 30 cycles → q frozen, no natural tick, pcnt still advances. A good rise during en=0 still realigns q to 0.

Source files
------------

// File: rtl/gps_clk_pkg.sv
// Shared clocking definitions for the GPS-disciplined second generator and time-of-day logic.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gps_clk_pkg;

  // Lock qualification states; encodings are visible to software and other blocks.
  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2,
    ST_HOLDOVER = 2'd3
  } pps_state_e;

  // Production defaults: 50 MHz core clock, +/-1000 cycle (20 ppm) acceptance window.
  localparam int DEF_WIDTH    = 28;
  localparam int DEF_DIV      = 50_000_000;
  localparam int DEF_TOL      = 1000;
  localparam int DEF_LOCK_CNT = 3;

endpackage

// File: rtl/gps_pps_divider_pps_sync.sv
// PPS front end: two-flop synchroniser followed by a rising-edge detector.
// Latency: rise asserts 2-3 clk cycles after the pps pin goes high; rise itself is combinational off flops.
// Backpressure: none; every synchronised rising edge yields exactly one rise cycle.
//
// Ports: clk (system clock), reset (sync, active low), pps (raw async 1PPS), rise (one-cycle edge pulse).
module pps_sync (
  input  logic clk,
  input  logic reset,
  input  logic pps,
  output logic rise
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic edge_q, edge_d;

  always_comb begin
    meta_d = pps;
    sync_d = meta_q;
    edge_d = sync_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      edge_q <= edge_d;
    end
  end

  assign rise = sync_q & ~edge_q;

endmodule

// File: rtl/gps_pps_divider.sv
// GPS-disciplined phase counter: free-runs modulo DIV, emits a one-cycle tick per second and
// realigns the phase to qualified 1PPS edges under a lock/holdover state machine.
// Latency: all outputs registered, 1 cycle after the synchronised rise; no backpressure (outputs are pulses/levels).
//
// Ports: clk, reset (sync active low), pps (raw GPS pulse), en (gates q advance only),
//        q (phase 0..DIV-1), tick (second pulse), locked, holdover (state flags),
//        last_period (cycles between last two PPS rises), period_valid (pulse on last_period update).
module gps_pps_divider
  import gps_clk_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DIV      = DEF_DIV,
  parameter int TOL      = DEF_TOL,
  parameter int LOCK_CNT = DEF_LOCK_CNT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pps,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             tick,
  output logic             locked,
  output logic             holdover,
  output logic [WIDTH-1:0] last_period,
  output logic             period_valid
);

  localparam int GW = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);

  localparam logic [WIDTH-1:0] WIN_LO    = WIDTH'(DIV - TOL);
  localparam logic [WIDTH-1:0] WIN_HI    = WIDTH'(DIV + TOL);
  localparam logic [WIDTH-1:0] Q_LAST    = WIDTH'(DIV - 1);
  localparam logic [WIDTH-1:0] Q_TOL     = WIDTH'(TOL);
  localparam logic [GW-1:0]    GOOD_LOCK = GW'(LOCK_CNT);

  logic rise;

  pps_sync u_pps_sync (
    .clk   (clk),
    .reset (reset),
    .pps   (pps),
    .rise  (rise)
  );

  pps_state_e       state_q, state_d;
  logic [GW-1:0]    good_cnt_q, good_cnt_d;
  logic [WIDTH-1:0] pcnt_q, pcnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             tick_q, tick_d;
  logic [WIDTH-1:0] lp_q, lp_d;
  logic             pv_q, pv_d;

  logic [WIDTH-1:0] pcnt_inc;
  logic [GW-1:0]    good_cnt_inc;
  logic             in_win;
  logic             good_rise;
  logic             bad_rise;
  logic             timeout;
  logic             realign;

  // Interval measurement. pcnt_inc is the length of the interval that ends this cycle;
  // it saturates so a lost GPS never wraps into a false "good" period.
  always_comb begin
    pcnt_inc  = (pcnt_q == '1) ? pcnt_q : pcnt_q + WIDTH'(1);
    in_win    = (pcnt_inc >= WIN_LO) && (pcnt_inc <= WIN_HI);
    good_rise = rise & in_win;
    bad_rise  = rise & ~in_win;
    // A rise landing exactly on the window edge is still a rise, not a timeout.
    timeout   = ~rise && (pcnt_inc == WIN_HI);

    pcnt_d = rise ? '0 : pcnt_inc;
    lp_d   = rise ? pcnt_inc : lp_q;
    pv_d   = rise;
  end

  // Lock qualification FSM.
  always_comb begin
    state_d      = state_q;
    good_cnt_d   = good_cnt_q;
    realign      = 1'b0;
    good_cnt_inc = good_cnt_q + GW'(1);

    case (state_q)
      ST_UNLOCKED: begin
        if (rise) begin
          state_d    = ST_ACQUIRE;
          good_cnt_d = '0;
          realign    = 1'b1;
        end
      end
      ST_ACQUIRE: begin
        if (rise) begin
          realign = 1'b1;
          if (good_rise) begin
            good_cnt_d = good_cnt_inc;
            if (good_cnt_inc >= GOOD_LOCK) begin
              state_d = ST_LOCKED;
            end
          end else begin
            good_cnt_d = '0;
          end
        end else if (timeout) begin
          state_d = ST_UNLOCKED;
        end
      end
      ST_LOCKED: begin
        // Once locked, a single out-of-window pulse is distrusted: drop back to
        // qualification but keep the current phase.
        if (good_rise) begin
          realign = 1'b1;
        end else if (bad_rise) begin
          state_d    = ST_ACQUIRE;
          good_cnt_d = '0;
        end else if (timeout) begin
          state_d = ST_HOLDOVER;
        end
      end
      ST_HOLDOVER: begin
        if (rise) begin
          state_d    = ST_ACQUIRE;
          good_cnt_d = '0;
          realign    = 1'b1;
        end
      end
      default: begin
        state_d    = ST_UNLOCKED;
        good_cnt_d = '0;
      end
    endcase
  end

  // Phase counter. A realign overrides the natural count; its tick is withheld when
  // q is still near zero, since that second's tick has already gone out.
  always_comb begin
    q_d    = q_q;
    tick_d = 1'b0;
    if (en) begin
      if (q_q == Q_LAST) begin
        q_d    = '0;
        tick_d = 1'b1;
      end else begin
        q_d = q_q + WIDTH'(1);
      end
    end
    if (realign) begin
      q_d    = '0;
      tick_d = (q_q >= Q_TOL);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_UNLOCKED;
      good_cnt_q <= '0;
      pcnt_q     <= '0;
      q_q        <= '0;
      tick_q     <= 1'b0;
      lp_q       <= '0;
      pv_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      pcnt_q     <= pcnt_d;
      q_q        <= q_d;
      tick_q     <= tick_d;
      lp_q       <= lp_d;
      pv_q       <= pv_d;
    end
  end

  assign q            = q_q;
  assign tick         = tick_q;
  assign locked       = (state_q == ST_LOCKED);
  assign holdover     = (state_q == ST_HOLDOVER);
  assign last_period  = lp_q;
  assign period_valid = pv_q;

endmodule

// File: tb/tb_gps_pps_divider.sv
// Self-checking bench for gps_pps_divider with WIDTH=8, DIV=100, TOL=5, LOCK_CNT=3.
// Inputs change on the falling edge, outputs are compared on the falling edge.
// An event-level reference model tracks PPS rise times, interval lengths and lock state.
module tb_gps_pps_divider;

  localparam int W   = 8;
  localparam int DIV = 100;
  localparam int TOL = 5;
  localparam int LC  = 3;

  localparam int S_UNL = 0;
  localparam int S_ACQ = 1;
  localparam int S_LCK = 2;
  localparam int S_HLD = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         pps;
  logic         en;
  logic [W-1:0] q;
  logic         tick;
  logic         locked;
  logic         holdover;
  logic [W-1:0] last_period;
  logic         period_valid;

  gps_pps_divider #(.WIDTH(W), .DIV(DIV), .TOL(TOL), .LOCK_CNT(LC)) dut (
    .clk          (clk),
    .reset        (reset),
    .pps          (pps),
    .en           (en),
    .q            (q),
    .tick         (tick),
    .locked       (locked),
    .holdover     (holdover),
    .last_period  (last_period),
    .period_valid (period_valid)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state (values after the most recent clock edge).
  int m_q    = 0;
  int m_lp   = 0;
  int m_st   = S_UNL;
  int m_good = 0;
  bit m_tick = 0;
  bit m_pv   = 0;
  int k      = 0;   // edge index
  int last_ref = 0; // edge index of last rise or reset
  bit ph0 = 0, ph1 = 0, ph2 = 0; // pps sampled 1, 2, 3 edges ago

  task automatic model_edge(input bit p, input bit e, input bit r);
    bit rise, good, bad, tmo, realign;
    int per, old_q;
    k++;
    if (!r) begin
      m_q = 0; m_lp = 0; m_st = S_UNL; m_good = 0; m_tick = 0; m_pv = 0;
      last_ref = k; ph0 = 0; ph1 = 0; ph2 = 0;
      return;
    end
    // A pin edge is seen two edges after it is first sampled high.
    rise = ph1 && !ph2;
    per  = k - last_ref;
    if (per > 255) per = 255;
    good = rise && (per >= DIV - TOL) && (per <= DIV + TOL);
    bad  = rise && !good;
    tmo  = !rise && (per == DIV + TOL);
    realign = 0;
    m_pv = rise;
    if (rise) begin
      m_lp = per;
      last_ref = k;
    end
    case (m_st)
      S_UNL: if (rise) begin m_st = S_ACQ; realign = 1; m_good = 0; end
      S_ACQ: begin
        if (rise) begin
          realign = 1;
          if (good) begin
            m_good++;
            if (m_good >= LC) m_st = S_LCK;
          end else m_good = 0;
        end else if (tmo) m_st = S_UNL;
      end
      S_LCK: begin
        if (good) realign = 1;
        else if (bad) begin m_st = S_ACQ; m_good = 0; end
        else if (tmo) m_st = S_HLD;
      end
      default: if (rise) begin m_st = S_ACQ; realign = 1; m_good = 0; end
    endcase
    old_q  = m_q;
    m_tick = 0;
    if (e) begin
      m_q = (m_q + 1) % DIV;
      m_tick = (m_q == 0);
    end
    if (realign) begin
      m_tick = (old_q >= TOL);
      m_q = 0;
    end
    ph2 = ph1; ph1 = ph0; ph0 = p;
  endtask

  function automatic logic [19:0] exp_vec();
    logic [19:0] v;
    v = {m_q[7:0], m_tick, (m_st == S_LCK), (m_st == S_HLD), m_lp[7:0], m_pv};
    return v;
  endfunction

  function automatic logic [19:0] dut_vec();
    return {q, tick, locked, holdover, last_period, period_valid};
  endfunction

  task automatic step(input bit p, input bit e, input bit r);
    pps = p; en = e; reset = r;
    @(posedge clk);
    model_edge(p, e, r);
    @(negedge clk);
  endtask

  // Reset then four 100-cycle pulses; leaves the DUT locked with the last pulse
  // sampled 10 steps ago (relative step 300 of 0..309).
  task automatic lock_seq();
    int w;
    w = $urandom_range(1, 8);
    step(0, 1, 0);
    step(0, 1, 0);
    for (int c = 0; c < 310; c++) step((c % 100) < w, 1, 1);
  endtask

  task automatic test_reset();
    step(0, 1, 0);
    step(0, 1, 0);
    if (dut_vec() !== 20'h0) begin
      n_err++; $display("FAIL reset_vals got=%h exp=%h", dut_vec(), 20'h0);
    end
    n_vec++;
    // pps already high while reset is held
    step(1, 1, 0);
    for (int c = 1; c <= 6; c++) begin
      step(1, 1, 1);
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL reset_model c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      end
      n_vec++;
      if (c == 2 && period_valid !== 1'b0) begin
        n_err++; $display("FAIL reset_early_rise got=%b exp=0", period_valid);
      end
      if (c == 2) n_vec++;
      if (c == 3) begin
        if ({period_valid, last_period, q, tick} !== {1'b1, 8'd3, 8'd0, 1'b0}) begin
          n_err++; $display("FAIL reset_rise3 pv/lp/q/tick got=%b/%0d/%0d/%b exp=1/3/0/0",
                            period_valid, last_period, q, tick);
        end
        n_vec++;
      end
    end
  endtask

  task automatic test_free_run();
    int ticks = 0, pvs = 0;
    step(0, 1, 0);
    for (int c = 0; c < 250; c++) begin
      step(0, 1, 1);
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL free_run c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      end
      n_vec++;
      if (tick) ticks++;
      if (period_valid) pvs++;
      if (c == 99 && (tick !== 1'b1 || q !== 8'd0)) begin
        n_err++; $display("FAIL free_run_wrap tick/q got=%b/%0d exp=1/0", tick, q);
      end
      if (c == 99) n_vec++;
    end
    if (ticks !== 2 || pvs !== 0 || locked !== 1'b0 || holdover !== 1'b0) begin
      n_err++; $display("FAIL free_run_counts ticks/pv/lk/ho got=%0d/%0d/%b/%b exp=2/0/0/0",
                        ticks, pvs, locked, holdover);
    end
    n_vec++;
  endtask

  task automatic test_lock();
    int w, pvs = 0;
    w = $urandom_range(1, 8);
    step(0, 1, 0);
    step(0, 1, 0);
    for (int c = 0; c < 310; c++) begin
      step((c % 100) < w, 1, 1);
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL lock c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      end
      n_vec++;
      if (period_valid) pvs++;
      if (c % 100 == 2) begin
        if (q !== 8'd0 || period_valid !== 1'b1 || (c > 2 && last_period !== 8'd100)) begin
          n_err++; $display("FAIL lock_rise c=%0d q/pv/lp got=%0d/%b/%0d exp=0/1/100", c, q, period_valid, last_period);
        end
        n_vec++;
      end
      if (c == 301 && locked !== 1'b0) begin
        n_err++; $display("FAIL lock_early got=%b exp=0", locked);
      end
      if (c == 302 && locked !== 1'b1) begin
        n_err++; $display("FAIL lock_set got=%b exp=1", locked);
      end
      if (c == 301 || c == 302) n_vec++;
    end
    if (pvs !== 4) begin
      n_err++; $display("FAIL lock_pv_count got=%0d exp=4", pvs);
    end
    n_vec++;
  endtask

  task automatic test_window();
    int w;
    bit p;
    lock_seq();
    w = $urandom_range(1, 8);
    for (int c = 310; c < 510; c++) begin
      p = (c >= 405 && c < 405 + w) || (c >= 499 && c < 499 + w);
      step(p, 1, 1);
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL window c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      end
      n_vec++;
      if (c == 407) begin
        if ({q, tick, locked, last_period} !== {8'd0, 1'b0, 1'b1, 8'd105}) begin
          n_err++; $display("FAIL window_105 q/tick/lk/lp got=%0d/%b/%b/%0d exp=0/0/1/105", q, tick, locked, last_period);
        end
        n_vec++;
      end
      if (c == 501) begin
        if ({q, locked, last_period} !== {8'd94, 1'b0, 8'd94}) begin
          n_err++; $display("FAIL window_94 q/lk/lp got=%0d/%b/%0d exp=94/0/94", q, locked, last_period);
        end
        n_vec++;
      end
    end
  endtask

  task automatic test_holdover();
    int w, ps, ticks = 0;
    bit p;
    lock_seq();
    w  = $urandom_range(1, 8);
    ps = 560 + $urandom_range(0, 30);
    for (int c = 310; c < ps + 10; c++) begin
      p = (c >= ps && c < ps + w);
      step(p, 1, 1);
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL holdover c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      end
      n_vec++;
      if (c < 560 && tick) ticks++;
      if (c == 406 || c == 407) begin
        if ({locked, holdover} !== ((c == 406) ? 2'b10 : 2'b01)) begin
          n_err++; $display("FAIL holdover_entry c=%0d lk/ho got=%b/%b exp=%0d", c, locked, holdover, (c == 406) ? 2 : 1);
        end
        n_vec++;
      end
      if (c == ps + 2) begin
        if ({holdover, locked, q, last_period} !== {1'b0, 1'b0, 8'd0, 8'd255}) begin
          n_err++; $display("FAIL holdover_exit ho/lk/q/lp got=%b/%b/%0d/%0d exp=0/0/0/255", holdover, locked, q, last_period);
        end
        n_vec++;
      end
    end
    if (ticks !== 2) begin
      n_err++; $display("FAIL holdover_ticks got=%0d exp=2", ticks);
    end
    n_vec++;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    lock_seq();
    while (m_q != 57 && n < 200) begin
      step(0, 1, 1);
      n++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL reset_mid_pre n=%0d got=%h exp=%h", n, dut_vec(), exp_vec());
      end
      n_vec++;
    end
    if (q !== 8'd57 || locked !== 1'b1) begin
      n_err++; $display("FAIL reset_mid_setup q/lk got=%0d/%b exp=57/1", q, locked);
    end
    n_vec++;
    step(0, 1, 0);
    if (dut_vec() !== 20'h0) begin
      n_err++; $display("FAIL reset_mid_clear got=%h exp=%h", dut_vec(), 20'h0);
    end
    n_vec++;
    for (int c = 0; c < 120; c++) begin
      step(c < 3 || (c >= 100 && c < 103), 1, 1);
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL reset_mid_post c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      end
      n_vec++;
    end
  endtask

  task automatic test_enable();
    int w;
    bit p, e;
    lock_seq();
    w = $urandom_range(1, 8);
    for (int c = 310; c < 430; c++) begin
      p = (c >= 400 && c < 400 + w);
      e = !(c >= 385 && c < 415);
      step(p, e, 1);
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL enable c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      end
      n_vec++;
      if (c >= 385 && c <= 401) begin
        if (q !== 8'd82 || tick !== 1'b0) begin
          n_err++; $display("FAIL enable_frozen c=%0d q/tick got=%0d/%b exp=82/0", c, q, tick);
        end
        n_vec++;
      end
      if (c == 402) begin
        if ({q, tick, last_period, locked} !== {8'd0, 1'b1, 8'd100, 1'b1}) begin
          n_err++; $display("FAIL enable_realign q/tick/lp/lk got=%0d/%b/%0d/%b exp=0/1/100/1", q, tick, last_period, locked);
        end
        n_vec++;
      end
      if (c > 402 && c < 415 && q !== 8'd0) begin
        n_err++; $display("FAIL enable_hold c=%0d q got=%0d exp=0", c, q);
      end
      if (c > 402 && c < 415) n_vec++;
    end
  endtask

  task automatic test_random();
    int gap, w, c, sel;
    bit p, e, r;
    step(0, 1, 0);
    gap = $urandom_range(20, 120);
    w = 1;
    c = 0;
    for (int i = 0; i < 3000; i++) begin
      if (c == gap) begin
        c = 0;
        sel = $urandom_range(0, 19);
        if (sel < 14)      gap = $urandom_range(94, 106);
        else if (sel < 17) gap = $urandom_range(60, 140);
        else               gap = $urandom_range(150, 300);
        w = $urandom_range(1, 10);
      end
      p = (c < w);
      e = ($urandom_range(0, 9) != 0);
      r = ($urandom_range(0, 799) != 0);
      step(p, e, r);
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL random i=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
      n_vec++;
      c++;
    end
  endtask

  initial begin
    pps = 1'b0;
    en = 1'b1;
    reset = 1'b0;
    test_reset();
    test_free_run();
    test_lock();
    test_window();
    test_holdover();
    test_reset_mid();
    test_enable();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
